// File: rtl/imem_loader_if.sv
// Byte-stream handshake bundle feeding the instruction-memory loader.
// The source drives one byte per cycle with valid/last; the loader answers with ready.
interface imem_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface : imem_loader_if

// File: rtl/imem_loader.sv
// Instruction memory loader: accepts a byte stream into a byte-addressed memory,
// serves big-endian 32-bit words to fetch combinationally, and keeps the
// pipeline stalled (cpu_en=0) until a load has completed.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  imem_loader_if.slave      in_if,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [31:0]       fetch_word,
  output logic              cpu_en,
  output logic              load_done,
  output logic              full,
  output logic [ADDR_W:0]   byte_count,
  output logic [7:0]        checksum
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   byte_count_q, byte_count_d;
  logic [7:0]        checksum_q, checksum_d;
  logic              full_q, full_d;
  logic              in_ready_q, in_ready_d;
  logic              cpu_en_q, cpu_en_d;
  logic              load_done_q, load_done_d;

  logic              accept_s;
  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;

  // Memory contents survive reset and reloads; only written bytes change.
  logic [7:0]        mem_q [DEPTH];

  // in_ready is a flop, so acceptance depends on in_valid only through this AND.
  assign accept_s  = in_if.in_valid & in_ready_q;
  assign wr_addr_s = byte_count_q[ADDR_W-1:0];

  // Next-state, counter and registered-output computation for the load FSM.
  always_comb begin
    state_d      = state_q;
    byte_count_d = byte_count_q;
    checksum_d   = checksum_q;
    full_d       = full_q;
    wr_en_s      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = LOAD;
          byte_count_d = '0;
          checksum_d   = 8'h00;
          full_d       = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      LOAD: begin
        // start is deliberately ignored here: counters keep running.
        if (accept_s) begin
          wr_en_s      = 1'b1;
          byte_count_d = byte_count_q + {{ADDR_W{1'b0}}, 1'b1};
          checksum_d   = checksum_q + in_if.in_data;
          if (in_if.in_last) begin
            state_d = DONE;
          end else if (byte_count_d == FULL_CNT) begin
            state_d = DONE;
            full_d  = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d      = IDLE;
        byte_count_d = '0;
        checksum_d   = 8'h00;
        full_d       = 1'b0;
      end
    endcase
    in_ready_d  = (state_d == LOAD) && (byte_count_d < FULL_CNT);
    cpu_en_d    = (state_d == DONE);
    load_done_d = (state_d == DONE) && (state_q != DONE);
  end

  // FSM state, counters and handshake/status outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      byte_count_q <= '0;
      checksum_q   <= 8'h00;
      full_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      cpu_en_q     <= 1'b0;
      load_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_count_q <= byte_count_d;
      checksum_q   <= checksum_d;
      full_q       <= full_d;
      in_ready_q   <= in_ready_d;
      cpu_en_q     <= cpu_en_d;
      load_done_q  <= load_done_d;
    end
  end

  // Byte write port; a write coinciding with reset is suppressed.
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      mem_q[wr_addr_s] <= in_if.in_data;
    end
  end

  // Fetch addresses wrap mod DEPTH through ADDR_W-bit arithmetic; no alignment needed.
  always_comb begin
    fetch_word = {mem_q[fetch_addr],
                  mem_q[fetch_addr + {{(ADDR_W-1){1'b0}}, 1'b1}],
                  mem_q[fetch_addr + {{(ADDR_W-2){1'b0}}, 2'd2}],
                  mem_q[fetch_addr + {{(ADDR_W-2){1'b0}}, 2'd3}]};
  end

  assign in_if.in_ready = in_ready_q;
  assign cpu_en         = cpu_en_q;
  assign load_done      = load_done_q;
  assign full           = full_q;
  assign byte_count     = byte_count_q;
  assign checksum       = checksum_q;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader.
module tb_imem_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] fetch_addr;
  logic [31:0] fetch_word;
  logic       cpu_en;
  logic       load_done;
  logic       full;
  logic [8:0] byte_count;
  logic [7:0] checksum;

  imem_loader_if bus ();

  imem_loader #(.ADDR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_if      (bus),
    .fetch_addr (fetch_addr),
    .fetch_word (fetch_word),
    .cpu_en     (cpu_en),
    .load_done  (load_done),
    .full       (full),
    .byte_count (byte_count),
    .checksum   (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  int ld_pulses;

  // Count load_done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (load_done === 1'b1) ld_pulses <= ld_pulses + 1;
  end

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic [8:0] cnt;
    logic [7:0] sum;
    logic       rdy;
    logic       en;
    logic       done;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    chk("send_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic set_row(input int i, input logic v, input logic [7:0] d, input logic l,
                         input logic [8:0] cnt, input logic [7:0] sum,
                         input logic rdy, input logic en, input logic done);
    tbl[i].v = v; tbl[i].d = d; tbl[i].l = l; tbl[i].cnt = cnt; tbl[i].sum = sum;
    tbl[i].rdy = rdy; tbl[i].en = en; tbl[i].done = done;
  endtask

  initial begin
    checks = 0; failures = 0; ld_pulses = 0;
    rst = 1'b1; start = 1'b0; fetch_addr = 8'h00;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0;

    // Basic load with a gap after every byte; expected values after each edge.
    set_row( 0, 1'b1, 8'h11, 1'b0, 9'd1, 8'h11, 1'b1, 1'b0, 1'b0);
    set_row( 1, 1'b0, 8'h00, 1'b0, 9'd1, 8'h11, 1'b1, 1'b0, 1'b0);
    set_row( 2, 1'b1, 8'h22, 1'b0, 9'd2, 8'h33, 1'b1, 1'b0, 1'b0);
    set_row( 3, 1'b0, 8'h00, 1'b0, 9'd2, 8'h33, 1'b1, 1'b0, 1'b0);
    set_row( 4, 1'b1, 8'h33, 1'b0, 9'd3, 8'h66, 1'b1, 1'b0, 1'b0);
    set_row( 5, 1'b0, 8'h00, 1'b0, 9'd3, 8'h66, 1'b1, 1'b0, 1'b0);
    set_row( 6, 1'b1, 8'h44, 1'b0, 9'd4, 8'hAA, 1'b1, 1'b0, 1'b0);
    set_row( 7, 1'b0, 8'h00, 1'b0, 9'd4, 8'hAA, 1'b1, 1'b0, 1'b0);
    set_row( 8, 1'b1, 8'h55, 1'b0, 9'd5, 8'hFF, 1'b1, 1'b0, 1'b0);
    set_row( 9, 1'b0, 8'h00, 1'b0, 9'd5, 8'hFF, 1'b1, 1'b0, 1'b0);
    set_row(10, 1'b1, 8'h66, 1'b0, 9'd6, 8'h65, 1'b1, 1'b0, 1'b0);
    set_row(11, 1'b0, 8'h00, 1'b0, 9'd6, 8'h65, 1'b1, 1'b0, 1'b0);
    set_row(12, 1'b1, 8'h77, 1'b0, 9'd7, 8'hDC, 1'b1, 1'b0, 1'b0);
    set_row(13, 1'b0, 8'h00, 1'b0, 9'd7, 8'hDC, 1'b1, 1'b0, 1'b0);
    set_row(14, 1'b1, 8'h88, 1'b1, 9'd8, 8'h64, 1'b0, 1'b1, 1'b1);
    set_row(15, 1'b0, 8'h00, 1'b0, 9'd8, 8'h64, 1'b0, 1'b1, 1'b0);

    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_ready",     {31'd0, bus.in_ready}, 32'd0);
    chk("rst_cpu_en",    {31'd0, cpu_en},       32'd0);
    chk("rst_load_done", {31'd0, load_done},    32'd0);
    chk("rst_full",      {31'd0, full},         32'd0);
    chk("rst_count",     {23'd0, byte_count},   32'd0);
    chk("rst_checksum",  {24'd0, checksum},     32'd0);

    // in_valid while IDLE must not be taken.
    bus.in_valid = 1'b1; bus.in_data = 8'h99;
    tick();
    bus.in_valid = 1'b0;
    chk("idle_count", {23'd0, byte_count}, 32'd0);
    chk("idle_ready", {31'd0, bus.in_ready}, 32'd0);

    ld_pulses = 0;
    pulse_start();
    chk("start_ready",  {31'd0, bus.in_ready}, 32'd1);
    chk("start_cpu_en", {31'd0, cpu_en},       32'd0);

    for (int i = 0; i < 16; i++) begin
      bus.in_valid = tbl[i].v;
      bus.in_data  = tbl[i].d;
      bus.in_last  = tbl[i].l;
      tick();
      chk($sformatf("tbl%0d_count", i),  {23'd0, byte_count}, {23'd0, tbl[i].cnt});
      chk($sformatf("tbl%0d_sum", i),    {24'd0, checksum},   {24'd0, tbl[i].sum});
      chk($sformatf("tbl%0d_ready", i),  {31'd0, bus.in_ready}, {31'd0, tbl[i].rdy});
      chk($sformatf("tbl%0d_cpu_en", i), {31'd0, cpu_en},     {31'd0, tbl[i].en});
      chk($sformatf("tbl%0d_done", i),   {31'd0, load_done},  {31'd0, tbl[i].done});
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    tick(); tick();
    chk("basic_done_pulses", ld_pulses, 32'd1);
    chk("basic_full", {31'd0, full}, 32'd0);
    fetch_addr = 8'h00; #1 chk("basic_fetch0", fetch_word, 32'h11223344);
    fetch_addr = 8'h04; #1 chk("basic_fetch4", fetch_word, 32'h55667788);
    fetch_addr = 8'h02; #1 chk("basic_fetch2", fetch_word, 32'h33445566);

    // Reload from DONE: pipeline stalls the very next cycle.
    pulse_start();
    chk("reload_cpu_en", {31'd0, cpu_en},     32'd0);
    chk("reload_count",  {23'd0, byte_count}, 32'd0);
    chk("reload_sum",    {24'd0, checksum},   32'd0);
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b1);
    chk("reload_cnt4",   {23'd0, byte_count}, 32'd4);
    chk("reload_sum4",   {24'd0, checksum},   32'h0E);
    chk("reload_en4",    {31'd0, cpu_en},     32'd1);
    fetch_addr = 8'h00; #1 chk("reload_fetch0", fetch_word, 32'hAABBCCDD);
    fetch_addr = 8'h04; #1 chk("reload_fetch4", fetch_word, 32'h55667788);

    // start during LOAD is ignored.
    pulse_start();
    send(8'h01, 1'b0); send(8'h02, 1'b0);
    pulse_start();
    chk("midstart_count", {23'd0, byte_count}, 32'd2);
    chk("midstart_ready", {31'd0, bus.in_ready}, 32'd1);
    send(8'h03, 1'b1);
    chk("midstart_cnt3", {23'd0, byte_count}, 32'd3);
    chk("midstart_sum3", {24'd0, checksum},   32'd6);
    fetch_addr = 8'h00; #1 chk("midstart_fetch0", fetch_word, 32'h010203DD);

    // Reset in the middle of a load keeps memory.
    pulse_start();
    send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_count",  {23'd0, byte_count},   32'd0);
    chk("mrst_sum",    {24'd0, checksum},     32'd0);
    chk("mrst_cpu_en", {31'd0, cpu_en},       32'd0);
    chk("mrst_ready",  {31'd0, bus.in_ready}, 32'd0);
    fetch_addr = 8'h00; #1 chk("mrst_fetch0", fetch_word, 32'hA1A2A3DD);
    pulse_start();
    for (int i = 1; i <= 8; i++) send(8'(i * 17), (i == 8) ? 1'b1 : 1'b0);
    chk("mrst_reload_cnt", {23'd0, byte_count}, 32'd8);
    chk("mrst_reload_sum", {24'd0, checksum},   32'h64);
    chk("mrst_reload_en",  {31'd0, cpu_en},     32'd1);
    fetch_addr = 8'h04; #1 chk("mrst_fetch4", fetch_word, 32'h55667788);

    // Full image: 256 bytes, no in_last.
    pulse_start();
    for (int i = 0; i < 256; i++) send(8'(i), 1'b0);
    chk("full_flag",   {31'd0, full},         32'd1);
    chk("full_count",  {23'd0, byte_count},   32'd256);
    chk("full_ready",  {31'd0, bus.in_ready}, 32'd0);
    chk("full_sum",    {24'd0, checksum},     32'h80);
    chk("full_en",     {31'd0, cpu_en},       32'd1);
    chk("full_done",   {31'd0, load_done},    32'd1);
    fetch_addr = 8'hFE; #1 chk("full_fetchFE", fetch_word, 32'hFEFF0001);
    fetch_addr = 8'hFF; #1 chk("full_fetchFF", fetch_word, 32'hFF000102);
    bus.in_valid = 1'b1; bus.in_data = 8'h55;
    tick();
    bus.in_valid = 1'b0;
    chk("full_hold_count", {23'd0, byte_count}, 32'd256);
    chk("full_done_low",   {31'd0, load_done},  32'd0);
    fetch_addr = 8'h00; #1 chk("full_fetch0", fetch_word, 32'h00010203);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_imem_loader
